controller_standby_mode_arbiter: RTL and testbench

- Sequences the hand-over of the shared TTI queues and the PHY between the I2C and I3C standby controllers.
- Replaces a combinational mode select with a registered select that changes only at a safe point. The safe point is: the outgoing controller is quiesced, the bus has been free for t_bus_free_i cycles, and no TTI write/read beat is in flight.
- Sits between the CSR configuration and the I2C/I3C standby controller pair, driving their enables and the TTI/PHY mux select.

---
 rtl/controller_standby_mode_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_controller_standby_mode_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/controller_standby_mode_arbiter.sv
// Registered I2C/I3C standby controller hand-over: drains the outgoing side, waits for bus-free,
// then flips the TTI/PHY select. Optional drain timeout: CONTROLLER_STANDBY_ARB_TIMEOUT_EN.
module controller_standby_mode_arbiter #(
    parameter int unsigned CntWidth      = 20,
    parameter int unsigned TimeoutCycles = 4096
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                phy_en_i,
    input  logic                i3c_active_en_i,
    input  logic                i3c_standby_en_i,
    input  logic                i2c_busy_i,
    input  logic                i3c_busy_i,
    input  logic                tti_beat_pending_i,
    input  logic                scl_i,
    input  logic                sda_i,
    input  logic [CntWidth-1:0] t_bus_free_i,
    output logic                i2c_en_o,
    output logic                i3c_en_o,
    output logic                i2c_stop_req_o,
    output logic                i3c_stop_req_o,
    output logic                sel_i3c_o,
    output logic                switching_o,
    output logic                switch_done_o,
    output logic                timeout_o
);

    typedef enum logic [2:0] {
        StDisabled,
        StOnI2c,
        StOnI3c,
        StDrain,
        StWaitFree,
        StHandover
    } state_e;

    state_e state_q, state_d;

    logic sel_q, sel_d;
    logic i2c_en_q, i2c_en_d;
    logic i3c_en_q, i3c_en_d;
    logic i2c_stop_q, i2c_stop_d;
    logic i3c_stop_q, i3c_stop_d;
    logic switching_q, switching_d;
    logic done_q, done_d;

    logic [CntWidth-1:0] free_cnt_q, free_cnt_d;

    logic target_i3c;
    logic out_busy;
    logic bus_idle;
    logic bus_free;
    logic drained;
    logic drain_expired;

    assign target_i3c = i3c_active_en_i | i3c_standby_en_i;
    // sel_q still names the outgoing controller until the hand-over cycle.
    assign out_busy   = sel_q ? i3c_busy_i : i2c_busy_i;
    assign bus_idle   = scl_i & sda_i;
    assign bus_free   = (free_cnt_q >= t_bus_free_i);
    assign drained    = ~out_busy & ~tti_beat_pending_i;

`ifdef CONTROLLER_STANDBY_ARB_TIMEOUT_EN
    localparam int unsigned DrainW = $clog2(TimeoutCycles + 1);

    logic [DrainW-1:0] drain_cnt_q, drain_cnt_d;
    logic              timeout_q, timeout_d;

    assign drain_expired = (state_q == StDrain) &&
                           (drain_cnt_q >= DrainW'(TimeoutCycles - 1));

    always_comb begin
        drain_cnt_d = '0;
        if (state_q == StDrain && !drain_expired) begin
            drain_cnt_d = drain_cnt_q + 1'b1;
        end
    end

    always_comb begin
        timeout_d = timeout_q;
        if (!phy_en_i) begin
            timeout_d = 1'b0;
        end else if (drain_expired && state_d == StWaitFree) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drain_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            drain_cnt_q <= drain_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TimeoutCycles;
    assign drain_expired      = 1'b0;
    assign timeout_o          = 1'b0;
`endif

    // Bus-free counter runs only in WAIT_FREE; any low on SCL/SDA restarts it.
    always_comb begin
        free_cnt_d = '0;
        if (state_q == StWaitFree && bus_idle) begin
            free_cnt_d = (&free_cnt_q) ? free_cnt_q : free_cnt_q + 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StDisabled;
            sel_q       <= 1'b0;
            i2c_en_q    <= 1'b0;
            i3c_en_q    <= 1'b0;
            i2c_stop_q  <= 1'b0;
            i3c_stop_q  <= 1'b0;
            switching_q <= 1'b0;
            done_q      <= 1'b0;
            free_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            i2c_en_q    <= i2c_en_d;
            i3c_en_q    <= i3c_en_d;
            i2c_stop_q  <= i2c_stop_d;
            i3c_stop_q  <= i3c_stop_d;
            switching_q <= switching_d;
            done_q      <= done_d;
            free_cnt_q  <= free_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (!phy_en_i) begin
            state_d = StDisabled;
        end else begin
            case (state_q)
                StDisabled: state_d = target_i3c ? StOnI3c : StOnI2c;
                StOnI2c: begin
                    if (target_i3c) state_d = StDrain;
                end
                StOnI3c: begin
                    if (!target_i3c) state_d = StDrain;
                end
                StDrain: begin
                    if (target_i3c == sel_q) begin
                        state_d = sel_q ? StOnI3c : StOnI2c;
                    end else if (drained || drain_expired) begin
                        state_d = StWaitFree;
                    end
                end
                StWaitFree: begin
                    if (target_i3c == sel_q) begin
                        state_d = sel_q ? StOnI3c : StOnI2c;
                    end else if (bus_free) begin
                        state_d = StHandover;
                    end
                end
                // sel_q has already toggled here, so it names the incoming side.
                StHandover: state_d = sel_q ? StOnI3c : StOnI2c;
                default:    state_d = StDisabled;
            endcase
        end
    end

    // Output logic: decoded from the next state so every output is a flop.
    always_comb begin
        sel_d       = sel_q;
        i2c_en_d    = 1'b0;
        i3c_en_d    = 1'b0;
        i2c_stop_d  = 1'b0;
        i3c_stop_d  = 1'b0;
        switching_d = 1'b0;
        done_d      = 1'b0;
        case (state_d)
            StOnI2c: begin
                sel_d    = 1'b0;
                i2c_en_d = 1'b1;
                done_d   = (state_q == StHandover);
            end
            StOnI3c: begin
                sel_d    = 1'b1;
                i3c_en_d = 1'b1;
                done_d   = (state_q == StHandover);
            end
            StDrain: begin
                i2c_en_d    = ~sel_q;
                i3c_en_d    = sel_q;
                i2c_stop_d  = ~sel_q;
                i3c_stop_d  = sel_q;
                switching_d = 1'b1;
            end
            StWaitFree: begin
                i2c_stop_d  = ~sel_q;
                i3c_stop_d  = sel_q;
                switching_d = 1'b1;
            end
            StHandover: begin
                sel_d       = ~sel_q;
                switching_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign sel_i3c_o      = sel_q;
    assign i2c_en_o       = i2c_en_q;
    assign i3c_en_o       = i3c_en_q;
    assign i2c_stop_req_o = i2c_stop_q;
    assign i3c_stop_req_o = i3c_stop_q;
    assign switching_o    = switching_q;
    assign switch_done_o  = done_q;

endmodule

// File: tb/tb_controller_standby_mode_arbiter.sv
// Directed bench for controller_standby_mode_arbiter; TimeoutCycles=16 so the
// CONTROLLER_STANDBY_ARB_TIMEOUT_EN build can be exercised as well.
module tb_controller_standby_mode_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        phy_en = 1'b0;
    logic        i3c_active = 1'b0;
    logic        i3c_standby = 1'b0;
    logic        i2c_busy = 1'b0;
    logic        i3c_busy = 1'b0;
    logic        pending = 1'b0;
    logic        scl = 1'b1;
    logic        sda = 1'b1;
    logic [19:0] t_bus_free = 20'd5;

    logic i2c_en, i3c_en, i2c_stop, i3c_stop, sel, switching, done, timeout;
    logic [7:0] obs;

    int checks = 0;
    int errors = 0;

    // {i2c_en, i3c_en, i2c_stop, i3c_stop, sel, switching, done, timeout}
    localparam logic [7:0] OFF0     = 8'b0000_0000;
    localparam logic [7:0] OFF1     = 8'b0000_1000;
    localparam logic [7:0] ON_I2C   = 8'b1000_0000;
    localparam logic [7:0] ON_I3C   = 8'b0100_1000;
    localparam logic [7:0] DONE_I2C = 8'b1000_0010;
    localparam logic [7:0] DONE_I3C = 8'b0100_1010;
    localparam logic [7:0] DRN_I2C  = 8'b1010_0100;
    localparam logic [7:0] DRN_I3C  = 8'b0101_1100;
    localparam logic [7:0] WT_I2C   = 8'b0010_0100;
    localparam logic [7:0] WT_I3C   = 8'b0001_1100;
    localparam logic [7:0] HO_TO3   = 8'b0000_1100;
    localparam logic [7:0] HO_TO2   = 8'b0000_0100;

    controller_standby_mode_arbiter #(
        .CntWidth      (20),
        .TimeoutCycles (16)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .phy_en_i           (phy_en),
        .i3c_active_en_i    (i3c_active),
        .i3c_standby_en_i   (i3c_standby),
        .i2c_busy_i         (i2c_busy),
        .i3c_busy_i         (i3c_busy),
        .tti_beat_pending_i (pending),
        .scl_i              (scl),
        .sda_i              (sda),
        .t_bus_free_i       (t_bus_free),
        .i2c_en_o           (i2c_en),
        .i3c_en_o           (i3c_en),
        .i2c_stop_req_o     (i2c_stop),
        .i3c_stop_req_o     (i3c_stop),
        .sel_i3c_o          (sel),
        .switching_o        (switching),
        .switch_done_o      (done),
        .timeout_o          (timeout)
    );

    assign obs = {i2c_en, i3c_en, i2c_stop, i3c_stop, sel, switching, done, timeout};

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Enables never overlap, and the select only moves after a cycle with both enables low.
    logic prev_sel = 1'b0;
    logic prev_off = 1'b1;
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            assert (!(i2c_en && i3c_en)) else begin
                errors++;
                $error("FAIL en_overlap observed %b%b expected not both 1", i2c_en, i3c_en);
            end
            if (sel !== prev_sel) begin
                checks++;
                assert (prev_off) else begin
                    errors++;
                    $error("FAIL sel_gap observed prev_off=%b expected 1", prev_off);
                end
            end
        end
        prev_sel <= sel;
        prev_off <= !i2c_en && !i3c_en;
    end

    initial begin
        // Reset and power-up into I3C
        step(1);
        check("reset", OFF0);
        #3 rst_n = 1'b1;
        step(1);
        check("disabled_idle", OFF0);
        phy_en = 1'b1;
        i3c_standby = 1'b1;
        step(1);
        check("pwr_i3c_c1", ON_I3C);
        step(1);
        check("pwr_i3c_c2", ON_I3C);

        // phy_en low keeps select, then power up into I2C
        phy_en = 1'b0;
        i3c_standby = 1'b0;
        step(1);
        check("phy_off_sel_held", OFF1);
        phy_en = 1'b1;
        step(1);
        check("pwr_i2c", ON_I2C);

        // I2C -> I3C with 10 busy cycles and t_bus_free=5
        i2c_busy = 1'b1;
        i3c_active = 1'b1;
        step(1);
        check("drain_i2c_first", DRN_I2C);
        for (int i = 0; i < 9; i++) begin
            step(1);
            check("drain_i2c_busy", DRN_I2C);
        end
        i2c_busy = 1'b0;
        step(1);
        check("wait_i2c_first", WT_I2C);
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("wait_i2c_idle", WT_I2C);
        end
        step(1);
        check("handover_to_i3c", HO_TO3);
        step(1);
        check("done_i3c", DONE_I3C);
        step(1);
        check("on_i3c_after", ON_I3C);

        // I3C -> I2C with an SDA glitch at count 6, t_bus_free=8
        t_bus_free = 20'd8;
        i3c_active = 1'b0;
        step(1);
        check("drain_i3c", DRN_I3C);
        step(1);
        check("wait_i3c_c0", WT_I3C);
        for (int i = 0; i < 6; i++) begin
            step(1);
            check("wait_i3c_pre", WT_I3C);
        end
        sda = 1'b0;
        step(1);
        check("wait_i3c_glitch", WT_I3C);
        sda = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1);
            check("wait_i3c_restart", WT_I3C);
        end
        step(1);
        check("handover_to_i2c", HO_TO2);
        step(1);
        check("done_i2c", DONE_I2C);
        step(1);
        check("on_i2c_after", ON_I2C);

        // Revert in DRAIN, then pending beat holds DRAIN, then revert in WAIT_FREE
        i2c_busy = 1'b1;
        i3c_active = 1'b1;
        step(1);
        check("rv_drain_a", DRN_I2C);
        step(1);
        check("rv_drain_b", DRN_I2C);
        i3c_active = 1'b0;
        step(1);
        check("rv_drain_back", ON_I2C);
        step(1);
        check("rv_drain_stay", ON_I2C);
        i2c_busy = 1'b0;
        pending = 1'b1;
        i3c_active = 1'b1;
        step(1);
        check("pend_drain_a", DRN_I2C);
        step(1);
        check("pend_drain_b", DRN_I2C);
        pending = 1'b0;
        step(1);
        check("rv_wait", WT_I2C);
        i3c_active = 1'b0;
        step(1);
        check("rv_wait_back", ON_I2C);

        // Asynchronous reset while in WAIT_FREE
        i3c_active = 1'b1;
        step(1);
        check("rst_drain", DRN_I2C);
        step(1);
        check("rst_wait", WT_I2C);
        #2 rst_n = 1'b0;
        #1 check("rst_async", OFF0);
        step(1);
        check("rst_held", OFF0);
        rst_n = 1'b1;
        step(1);
        check("rst_recover_i3c", ON_I3C);
        step(1);
        check("rst_recover_stay", ON_I3C);

        // Drain with the outgoing I3C controller stuck busy
        t_bus_free = 20'd0;
        i3c_active = 1'b0;
        i3c_busy = 1'b1;
        step(1);
        check("to_drain_c1", DRN_I3C);
        for (int i = 0; i < 15; i++) begin
            step(1);
            check("to_drain_hold", DRN_I3C);
        end
`ifdef CONTROLLER_STANDBY_ARB_TIMEOUT_EN
        step(1);
        check("to_wait_forced", WT_I3C | 8'h01);
        step(1);
        check("to_handover", HO_TO2 | 8'h01);
        step(1);
        check("to_done", DONE_I2C | 8'h01);
        step(1);
        check("to_sticky", ON_I2C | 8'h01);
`else
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("to_no_timeout", DRN_I3C);
        end
        i3c_busy = 1'b0;
        step(1);
        check("to_wait_free0", WT_I3C);
        step(1);
        check("to_handover", HO_TO2);
        step(1);
        check("to_done", DONE_I2C);
`endif
        i3c_busy = 1'b0;
        phy_en = 1'b0;
        step(1);
        check("final_off", OFF0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
